// File: rtl/wb_pio_ctrl.sv
// Wishbone front-end for NUM_PIO PIO cores: registered request FSM, program-load
// index counters, timed per-core soft reset and a sticky maskable IRQ aggregator.
//
// state    | meaning
// ST_IDLE  | waiting for an address hit; latches adr/dat/sel/we on hit
// ST_ISSUE | drives the action to the selected core, captures read data
// ST_ACK   | one-cycle acknowledge; index, soft-reset and local-reg writes commit
module wb_pio_ctrl #(
  parameter int          NUM_PIO    = 2,
  parameter logic [15:0] BASE_ADDR  = 16'h3000,
  parameter int          IDX_W      = 5,
  parameter int          RST_CYCLES = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_PIO-1:0]       pio_rst_o,
  output logic [4*NUM_PIO-1:0]     pio_action_o,
  output logic [1:0]               pio_mindex_o,
  output logic [IDX_W*NUM_PIO-1:0] pio_index_o,
  output logic [31:0]              pio_din_o,
  input  logic [32*NUM_PIO-1:0]    pio_dout_i,
  input  logic [2*NUM_PIO-1:0]     pio_irq_i,
  output logic                     irq_o
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);
  localparam int IRQ_W = 2 * NUM_PIO;
  localparam logic [31:0] ID_VAL = {8'h01, 8'(NUM_PIO), 8'(IDX_W), 8'h00};

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACK} state_t;
  state_t state_q, state_d;

  logic [11:2]      adr_q;
  logic [31:0]      dat_q;
  logic [3:0]       sel_q;
  logic             we_q;
  logic [31:0]      rd_q;
  logic             hit_ok_q;
  logic [IDX_W-1:0] idx_q [NUM_PIO];
  logic [CNT_W-1:0] cnt_q [NUM_PIO];
  logic [IRQ_W-1:0] status_q, enable_q;
  logic             irq_q;

  logic             hit, is_local, core_ok, wr_ack, local_wr, soft_go, inc_go;
  logic [1:0]       core_sel;
  logic [3:0]       act;
  logic [31:0]      din_m, core_dout, local_rd;
  logic [NUM_PIO-1:0] core_hot, core_busy;
  logic [IRQ_W-1:0] w1c;
  logic             unused_adr;

  assign unused_adr = ^{wbs_adr_i[15:12], wbs_adr_i[1:0]};
  assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_ADDR);
  assign is_local = adr_q[11];
  assign core_sel = adr_q[9:8];
  assign act      = adr_q[5:2];

  always_comb begin
    for (int n = 0; n < 4; n++)
      din_m[8*n +: 8] = sel_q[n] ? dat_q[8*n +: 8] : 8'h00;
  end

  // core_hot is all-zero for a core select beyond NUM_PIO, so such accesses do nothing
  always_comb begin
    core_dout = 32'h0;
    for (int k = 0; k < NUM_PIO; k++) begin
      core_hot[k]  = (core_sel == 2'(k));
      core_busy[k] = (cnt_q[k] != '0);
      if (core_hot[k]) core_dout = pio_dout_i[32*k +: 32];
    end
  end

  assign core_ok = !is_local && |(core_hot & ~core_busy);

  always_comb begin
    local_rd = 32'h0;
    if (adr_q[10:4] == '0) begin
      case (adr_q[3:2])
        2'd0:    local_rd = 32'(status_q);
        2'd1:    local_rd = 32'(enable_q);
        2'd2:    local_rd = ID_VAL;
        default: local_rd = 32'h0;
      endcase
    end
  end

  assign wr_ack   = (state_q == ST_ACK) && we_q;
  assign local_wr = wr_ack && is_local && (adr_q[10:4] == '0);
  assign w1c      = (local_wr && adr_q[3:2] == 2'd0) ? din_m[IRQ_W-1:0] : '0;
  assign soft_go  = wr_ack && hit_ok_q && (act == 4'd0) && din_m[31];
  assign inc_go   = wr_ack && hit_ok_q && (act == 4'd1);

  always_comb begin
    state_d      = state_q;
    pio_action_o = '0;
    case (state_q)
      ST_IDLE:  if (hit) state_d = ST_ISSUE;
      ST_ISSUE: begin
        state_d = ST_ACK;
        for (int k = 0; k < NUM_PIO; k++)
          if (core_ok && core_hot[k]) pio_action_o[4*k +: 4] = act;
      end
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      hit_ok_q <= 1'b0;
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= 1'b0;
      for (int k = 0; k < NUM_PIO; k++) begin
        idx_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && hit) begin
        adr_q <= wbs_adr_i[11:2];
        dat_q <= wbs_dat_i;
        sel_q <= wbs_sel_i;
        we_q  <= wbs_we_i;
      end
      if (state_q == ST_ISSUE) begin
        rd_q     <= is_local ? local_rd : (core_ok ? core_dout : 32'h0);
        hit_ok_q <= core_ok;
      end
      // a new irq in the same cycle as its W1C keeps the bit set
      status_q <= (status_q & ~w1c) | pio_irq_i;
      if (local_wr && adr_q[3:2] == 2'd1) enable_q <= din_m[IRQ_W-1:0];
      irq_q <= |(status_q & enable_q);
      for (int k = 0; k < NUM_PIO; k++) begin
        if (soft_go && core_hot[k]) begin
          cnt_q[k] <= CNT_W'(RST_CYCLES);
          idx_q[k] <= '0;
        end else begin
          if (cnt_q[k] != '0) cnt_q[k] <= cnt_q[k] - CNT_W'(1);
          if (inc_go && core_hot[k])
            idx_q[k] <= idx_q[k] + IDX_W'(din_m[19:16]) + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_PIO; k++) begin
      pio_rst_o[k]                 = wb_rst_i | core_busy[k];
      pio_index_o[IDX_W*k +: IDX_W] = idx_q[k];
    end
  end

  assign pio_mindex_o = adr_q[7:6];
  assign pio_din_o    = din_m;
  assign wbs_ack_o    = (state_q == ST_ACK);
  assign wbs_dat_o    = (state_q == ST_ACK) ? rd_q : 32'h0;
  assign irq_o        = irq_q;

endmodule

// File: tb/tb_wb_pio_ctrl.sv
// Directed self-checking bench for wb_pio_ctrl (NUM_PIO=2, IDX_W=5, RST_CYCLES=4).
module tb_wb_pio_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [1:0]  pio_rst_o;
  logic [7:0]  pio_action_o;
  logic [1:0]  pio_mindex_o;
  logic [9:0]  pio_index_o;
  logic [31:0] pio_din_o;
  logic [63:0] pio_dout_i = 64'h0;
  logic [3:0]  pio_irq_i = 4'h0;
  logic        irq_o;

  int n_total = 0;
  int n_pass  = 0;

  wb_pio_ctrl #(.NUM_PIO(2), .BASE_ADDR(16'h3000), .IDX_W(5), .RST_CYCLES(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .pio_rst_o(pio_rst_o), .pio_action_o(pio_action_o), .pio_mindex_o(pio_mindex_o),
    .pio_index_o(pio_index_o), .pio_din_o(pio_din_o), .pio_dout_i(pio_dout_i),
    .pio_irq_i(pio_irq_i), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
    end
  endtask

  // Starts and ends at a negedge. lat = posedges from request to ack (bounded).
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdata, output int lat,
                         output logic got, output logic [7:0] act_iss,
                         output logic [31:0] din_iss, output logic [7:0] act_ack,
                         output logic ack_after);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    lat = 0; got = 1'b0; act_iss = 8'h0; din_iss = 32'h0;
    while (!got && lat < 8) begin
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      lat = lat + 1;
      if (lat == 1) begin
        act_iss = pio_action_o;
        din_iss = pio_din_o;
      end
      got = wbs_ack_o;
    end
    act_ack = pio_action_o;
    rdata   = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    ack_after = wbs_ack_o;
  endtask

  logic [31:0] rd, din_iss;
  logic [7:0]  act_iss, act_ack;
  logic        got, ack_after;
  int          lat, rcnt, r0cnt, ackcnt;

  initial begin
    // reset values
    repeat (2) @(negedge wb_clk_i);
    chk("rst_pio_rst", 32'(pio_rst_o), 32'h3);
    chk("rst_ack", 32'(wbs_ack_o), 32'h0);
    chk("rst_index", 32'(pio_index_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    wb_rst_i = 1'b0;
    cyc_n(1);
    chk("post_rst_pio_rst", 32'(pio_rst_o), 32'h0);

    // program load on core 1
    wb_xfer(1'b1, 32'h3000_0104, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("load_lat", 32'(lat), 32'd2);
    chk("load_action_issue", 32'(act_iss), 32'h10);
    chk("load_idx1_a", 32'(pio_index_o[9:5]), 32'd1);
    wb_xfer(1'b1, 32'h3000_0104, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("load_idx1_b", 32'(pio_index_o[9:5]), 32'd2);
    wb_xfer(1'b1, 32'h3000_0104, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("load_idx1_c", 32'(pio_index_o[9:5]), 32'd3);
    wb_xfer(1'b1, 32'h3000_0104, 32'h0003_0000, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("load_idx1_skip", 32'(pio_index_o[9:5]), 32'd7);
    wb_xfer(1'b1, 32'h3000_0104, 32'h000F_0000, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("load_idx1_23", 32'(pio_index_o[9:5]), 32'd23);
    wb_xfer(1'b1, 32'h3000_0104, 32'h0007_0000, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("load_idx1_31", 32'(pio_index_o[9:5]), 32'd31);
    wb_xfer(1'b1, 32'h3000_0104, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("load_idx1_wrap", 32'(pio_index_o[9:5]), 32'd0);
    chk("load_idx0_same", 32'(pio_index_o[4:0]), 32'd0);

    // read timing on core 0 and core 1 with mindex 3
    pio_dout_i = {32'h1234_5678, 32'hDEAD_BEEF};
    wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_action_issue", 32'(act_iss), 32'h02);
    chk("rd_action_ack", 32'(act_ack), 32'h00);
    chk("rd_data", rd, 32'hDEAD_BEEF);
    chk("rd_ack_width", 32'(ack_after), 32'h0);
    wb_xfer(1'b0, 32'h3000_01C8, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("rd1_data", rd, 32'h1234_5678);
    chk("rd1_action_issue", 32'(act_iss), 32'h20);
    chk("rd1_mindex", 32'(pio_mindex_o), 32'd3);

    // reads never move the index
    wb_xfer(1'b1, 32'h3000_0104, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    wb_xfer(1'b0, 32'h3000_0104, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("rd_keeps_idx1", 32'(pio_index_o[9:5]), 32'd1);

    // soft reset of core 1
    wb_xfer(1'b1, 32'h3000_0100, 32'h8000_0000, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("srst_idx1_clear", 32'(pio_index_o[9:5]), 32'd0);
    rcnt = 0; r0cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (pio_rst_o[1]) rcnt = rcnt + 1;
      if (pio_rst_o[0]) r0cnt = r0cnt + 1;
      cyc_n(1);
    end
    chk("srst_len", 32'(rcnt), 32'd4);
    chk("srst_core0_quiet", 32'(r0cnt), 32'd0);

    // access to a core in soft reset: acked, no action, data 0
    wb_xfer(1'b1, 32'h3000_0100, 32'h8000_0000, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    wb_xfer(1'b0, 32'h3000_0108, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("busy_ack", 32'(got), 32'h1);
    chk("busy_action", 32'(act_iss), 32'h00);
    chk("busy_data", rd, 32'h0);
    cyc_n(6);

    // masked-off bit 31: no soft reset
    wb_xfer(1'b1, 32'h3000_0104, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    wb_xfer(1'b1, 32'h3000_0100, 32'h8000_0000, 4'h7, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    rcnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (pio_rst_o[1]) rcnt = rcnt + 1;
      cyc_n(1);
    end
    chk("nosrst_len", 32'(rcnt), 32'd0);
    chk("nosrst_idx1", 32'(pio_index_o[9:5]), 32'd1);

    // byte lanes
    wb_xfer(1'b1, 32'h3000_000C, 32'h1122_3344, 4'b0101, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("lane_din", din_iss, 32'h0022_0044);
    chk("lane_action", 32'(act_iss), 32'h03);

    // local registers and IRQ
    wb_xfer(1'b0, 32'h3000_0808, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("id_reg", rd, 32'h0102_0500);
    wb_xfer(1'b1, 32'h3000_0804, 32'h2, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    wb_xfer(1'b0, 32'h3000_0804, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("enable_rb", rd, 32'h2);
    pio_irq_i = 4'h2;
    cyc_n(1);
    pio_irq_i = 4'h0;
    chk("irq_lag", 32'(irq_o), 32'h0);
    cyc_n(1);
    chk("irq_set", 32'(irq_o), 32'h1);
    wb_xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("status_set", rd, 32'h2);
    pio_irq_i = 4'h2;
    wb_xfer(1'b1, 32'h3000_0800, 32'h2, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    wb_xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("status_set_wins", rd, 32'h2);
    pio_irq_i = 4'h0;
    wb_xfer(1'b1, 32'h3000_0800, 32'h2, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    cyc_n(1);
    chk("irq_clear", 32'(irq_o), 32'h0);
    pio_irq_i = 4'h1;
    cyc_n(1);
    pio_irq_i = 4'h0;
    cyc_n(2);
    chk("irq_masked", 32'(irq_o), 32'h0);
    wb_xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("status_masked_bit", rd, 32'h1);

    // core select beyond NUM_PIO, and a non-matching base
    wb_xfer(1'b0, 32'h3000_0300, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("oor_ack", 32'(got), 32'h1);
    chk("oor_data", rd, 32'h0);
    chk("oor_action", 32'(act_iss), 32'h00);
    wb_xfer(1'b0, 32'h3001_0000, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("miss_no_ack", 32'(got), 32'h0);

    // reset during ISSUE aborts the transfer
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3000_0008; wbs_sel_i = 4'hF; wbs_dat_i = 32'hFFFF_FFFF;
    cyc_n(1);
    chk("abort_issue_action", 32'(pio_action_o), 32'h02);
    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    cyc_n(1);
    chk("abort_ack", 32'(wbs_ack_o), 32'h0);
    chk("abort_dat", wbs_dat_o, 32'h0);
    chk("abort_action", 32'(pio_action_o), 32'h0);
    chk("abort_pio_rst", 32'(pio_rst_o), 32'h3);
    chk("abort_index", 32'(pio_index_o), 32'h0);
    chk("abort_din", pio_din_o, 32'h0);
    wb_rst_i = 1'b0;
    ackcnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc_n(1);
      if (wbs_ack_o) ackcnt = ackcnt + 1;
    end
    chk("abort_no_late_ack", 32'(ackcnt), 32'h0);
    wb_xfer(1'b0, 32'h3000_0804, 32'h0, 4'hF, rd, lat, got, act_iss, din_iss, act_ack, ack_after);
    chk("abort_enable_cleared", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
